seq_divider_ctrl: RTL and testbench

//  Multi-cycle controller for unsigned 8-bit restoring division (dividend / divisor).

---
 rtl/seq_divider_ctrl_pkg.sv | 9 +
 rtl/seq_divider_ctrl_sub.sv | 9 +
 rtl/seq_divider_ctrl.sv | 85 ++++++++
 tb/tb_seq_divider_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/seq_divider_ctrl_pkg.sv
// seq_divider_ctrl_pkg: shared FSM encodings, iteration bound and defaults for the divider
package seq_divider_ctrl_pkg;
  localparam int unsigned DIV_WIDTH = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [2:0] ITER_LAST = 3'd7;
  localparam logic [DIV_WIDTH-1:0] DZ_QUOT_DEF = 8'hFF;
endpackage

// File: rtl/seq_divider_ctrl_sub.sv
// eight_bit_subtracter: diff=a-b; c_out=1 when no borrow (a>=b); ports a,b in, diff,c_out out
module eight_bit_subtracter (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] diff,
  output logic       c_out
);
  assign {c_out, diff} = {1'b0, a} + {1'b0, ~b} + 9'd1;
endmodule

// File: rtl/seq_divider_ctrl.sv
// seq_divider_ctrl: 8-bit restoring divider FSM; start/busy/done handshake, quotient/remainder/div_by_zero outputs
module seq_divider_ctrl
  import seq_divider_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter logic [WIDTH-1:0] DZ_QUOT = DZ_QUOT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d, d_q, d_d, quot_q, quot_d, rem_q, rem_d;
  logic dz_q, dz_d;
  logic [WIDTH-1:0] t, diff;
  logic c_out;
  assign t = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  eight_bit_subtracter u_sub (.a(t), .b(d_q), .diff(diff), .c_out(c_out));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    q_d = q_q;
    r_d = r_q;
    d_d = d_q;
    quot_d = quot_q;
    rem_d = rem_q;
    dz_d = dz_q;
    if (state_q == S_IDLE && start && divisor != '0) begin
      q_d = dividend;
      d_d = divisor;
      r_d = '0;
      cnt_d = ITER_LAST;
      dz_d = 1'b0;
      state_d = S_ITER;
    end else if (state_q == S_IDLE && start) begin
      quot_d = DZ_QUOT;
      rem_d = dividend;
      dz_d = 1'b1;
      state_d = S_DONE;
    end else if (state_q == S_ITER) begin
      r_d = c_out ? diff : t;
      q_d = {q_q[WIDTH-2:0], c_out};
      cnt_d = cnt_q - 3'd1;
      quot_d = cnt_q == '0 ? q_d : quot_q;
      rem_d = cnt_q == '0 ? r_d : rem_q;
      state_d = cnt_q == '0 ? S_DONE : S_ITER;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      q_q <= '0;
      r_q <= '0;
      d_q <= '0;
      quot_q <= '0;
      rem_q <= '0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      q_q <= q_d;
      r_q <= r_d;
      d_q <= d_d;
      quot_q <= quot_d;
      rem_q <= rem_d;
      dz_q <= dz_d;
    end
  end
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  assign quotient = quot_q;
  assign remainder = rem_q;
  assign div_by_zero = dz_q;
endmodule

// File: tb/tb_seq_divider_ctrl.sv
// tb_seq_divider_ctrl: scoreboard bench for seq_divider_ctrl with directed and random divisions
module tb_seq_divider_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [7:0] quotient, remainder;
  int cyc = 0, n_tests = 0, n_fail = 0;
  typedef struct {
    logic [7:0] a, b, q, r;
    logic dz;
    int cyc;
  } exp_t;
  exp_t sb[$];
  seq_divider_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dz);
        chk("latency", cyc, e.cyc);
        if (!e.dz) begin
          chk("identity", quotient * e.b + remainder, e.a);
          chk("rem_lt_div", remainder < e.b, 1);
        end
      end
    end
  end
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q,
                       input logic [7:0] r, input logic dz);
    exp_t e;
    e.a = a; e.b = b; e.q = q; e.r = r; e.dz = dz;
    e.cyc = cyc + (dz ? 1 : 9);
    sb.push_back(e);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = 8'($urandom);
    divisor = 8'($urandom);
  endtask
  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask
  initial begin
    logic [7:0] a, b;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    chk("busy_after_start", busy, 1);
    wait_done();
    @(negedge clk);
    issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    wait_done();
    @(negedge clk);
    chk("idle_gap_busy", busy, 0);
    issue(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    chk("b2b_busy", busy, 1);
    wait_done();
    @(negedge clk);
    issue(8'd200, 8'd0, 8'd255, 8'd200, 1'b1);
    wait_done();
    @(negedge clk);
    issue(8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
    chk("dz_cleared", div_by_zero, 0);
    wait_done();
    @(negedge clk);
    issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    repeat (3) @(negedge clk);
    dividend = 8'd50;
    divisor = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
    issue(8'd255, 8'd16, 8'd15, 8'd15, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_quot", quotient, 0);
    chk("midrst_rem", remainder, 0);
    chk("midrst_dz", div_by_zero, 0);
    repeat (10) @(negedge clk);
    issue(8'd255, 8'd16, 8'd15, 8'd15, 1'b0);
    wait_done();
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (i % 50 == 0) b = '0;
      if (b == '0) issue(a, b, 8'hFF, a, 1'b1);
      else issue(a, b, a / b, a % b, 1'b0);
      wait_done();
      @(negedge clk);
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
